// File: rtl/dac_serial_rx_pkg.sv
// Shared definitions for the AD8803-style serial frame receiver.
// Field widths, frame length and FSM state encodings.
package dac_serial_rx_pkg;
  localparam int ADDR_BITS  = 3;
  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = ADDR_BITS + DATA_BITS;
  localparam int CNT_BITS   = 4;
  localparam int NUM_CH     = 1 << ADDR_BITS;

  localparam logic [CNT_BITS-1:0] FRAME_LEN = CNT_BITS'(FRAME_BITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } state_t;
endpackage

// File: rtl/dac_serial_rx_if.sv
// 3-wire DAC serial link: frame select, serial clock, serial data.
// The sender drives the master side, receivers sit on the slave side.
interface dac_serial_rx_if;
  logic SER_CS;
  logic SER_CLK;
  logic SER_SDI;

  modport master (output SER_CS, output SER_CLK, output SER_SDI);
  modport slave  (input  SER_CS, input  SER_CLK, input  SER_SDI);
endinterface

// File: rtl/dac_serial_rx_ser_sync.sv
// Multi-stage synchronizer with rise/fall pulses taken from the
// last two stages; reset value selects the idle level of the line.
module ser_sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter bit RST_VAL     = 1'b0
) (
  input  logic tx_clk,
  input  logic OPB_RST,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES:0] sr;

  always_ff @(posedge tx_clk or posedge OPB_RST) begin
    if (OPB_RST) sr <= {(SYNC_STAGES+1){RST_VAL}};
    else         sr <= {sr[SYNC_STAGES-1:0], din};
  end

  assign sync = sr[SYNC_STAGES-1];
  assign rise = sr[SYNC_STAGES-1] & ~sr[SYNC_STAGES];
  assign fall = ~sr[SYNC_STAGES-1] & sr[SYNC_STAGES];
endmodule

// File: rtl/dac_serial_rx.sv
// Serial frame receiver/monitor: decodes 11-bit addr+data frames
// into an 8-entry shadow bank and flags short/long frames.
module dac_serial_rx
  import dac_serial_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                 tx_clk,
  input  logic                 OPB_RST,
  dac_serial_rx_if.slave       ser,
  input  logic                 CLR,
  input  logic [ADDR_BITS-1:0] RD_ADDR,
  output logic [DATA_BITS-1:0] RD_DATA,
  output logic                 FRAME_STB,
  output logic [ADDR_BITS-1:0] FRAME_ADDR,
  output logic [DATA_BITS-1:0] FRAME_DATA,
  output logic [15:0]          FRAME_CNT,
  output logic                 ERR_SHORT,
  output logic                 ERR_LONG,
  output logic                 BUSY
);
  state_t state, state_nxt;

  logic [CNT_BITS-1:0]   bit_cnt;
  logic [FRAME_BITS-1:0] shreg;
  logic [DATA_BITS-1:0]  bank [NUM_CH];
  logic [15:0]           frame_cnt;
  logic commit, short_err, long_err;

  logic cs_s, cs_rise, cs_fall;
  logic clk_s, clk_rise, clk_fall;
  logic sdi_s, sdi_rise, sdi_fall;
  logic unused_sync;

  // CLK idles high, so its chain resets high to avoid a false rise.
  ser_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_cs (
    .tx_clk(tx_clk), .OPB_RST(OPB_RST), .din(ser.SER_CS),
    .sync(cs_s), .rise(cs_rise), .fall(cs_fall)
  );

  ser_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_clk (
    .tx_clk(tx_clk), .OPB_RST(OPB_RST), .din(ser.SER_CLK),
    .sync(clk_s), .rise(clk_rise), .fall(clk_fall)
  );

  ser_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sdi (
    .tx_clk(tx_clk), .OPB_RST(OPB_RST), .din(ser.SER_SDI),
    .sync(sdi_s), .rise(sdi_rise), .fall(sdi_fall)
  );

  assign unused_sync = ^{cs_s, clk_s, clk_fall, sdi_rise, sdi_fall};

  always_ff @(posedge tx_clk or posedge OPB_RST) begin
    if (OPB_RST) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (cs_fall) state_nxt = SHIFT;
      SHIFT:   if (cs_rise) state_nxt = CHECK;
      CHECK:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    BUSY      = 1'b0;
    commit    = 1'b0;
    short_err = 1'b0;
    long_err  = 1'b0;
    unique case (1'b1)
      (state == SHIFT): BUSY = 1'b1;
      (state == CHECK): begin
        commit    = (bit_cnt == FRAME_LEN);
        short_err = (bit_cnt <  FRAME_LEN);
        long_err  = (bit_cnt >  FRAME_LEN);
      end
      default: ;
    endcase
  end

  assign FRAME_STB = commit;

  // A clock rise coincident with the CS rise belongs to no frame.
  always_ff @(posedge tx_clk or posedge OPB_RST) begin
    if (OPB_RST) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (state == IDLE && cs_fall) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (state == SHIFT && clk_rise && !cs_rise) begin
      shreg <= {shreg[FRAME_BITS-2:0], sdi_s};
      if (bit_cnt != '1) bit_cnt <= bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge tx_clk or posedge OPB_RST) begin
    if (OPB_RST) begin
      for (int i = 0; i < NUM_CH; i++) bank[i] <= '0;
    end else if (commit) begin
      bank[shreg[FRAME_BITS-1 -: ADDR_BITS]] <= shreg[DATA_BITS-1:0];
    end
  end

  assign RD_DATA = bank[RD_ADDR];

  always_ff @(posedge tx_clk or posedge OPB_RST) begin
    if (OPB_RST) begin
      FRAME_ADDR <= '0;
      FRAME_DATA <= '0;
    end else if (commit) begin
      FRAME_ADDR <= shreg[FRAME_BITS-1 -: ADDR_BITS];
      FRAME_DATA <= shreg[DATA_BITS-1:0];
    end
  end

  // CLR takes priority over a same-cycle commit or error.
  always_ff @(posedge tx_clk or posedge OPB_RST) begin
    if (OPB_RST) begin
      frame_cnt <= '0;
      ERR_SHORT <= 1'b0;
      ERR_LONG  <= 1'b0;
    end else if (CLR) begin
      frame_cnt <= '0;
      ERR_SHORT <= 1'b0;
      ERR_LONG  <= 1'b0;
    end else begin
      if (commit)    frame_cnt <= frame_cnt + 16'd1;
      if (short_err) ERR_SHORT <= 1'b1;
      if (long_err)  ERR_LONG  <= 1'b1;
    end
  end

  assign FRAME_CNT = frame_cnt;
endmodule

// File: tb/tb_dac_serial_rx.sv
// Directed, table-driven bench for dac_serial_rx with a small
// shadow-bank model and hand-written multi-cycle corner sequences.
`timescale 1ns/1ps
module tb_dac_serial_rx;
  logic        tx_clk = 1'b0;
  logic        OPB_RST = 1'b1;
  logic        CLR = 1'b0;
  logic [2:0]  RD_ADDR = '0;
  logic [7:0]  RD_DATA;
  logic        FRAME_STB;
  logic [2:0]  FRAME_ADDR;
  logic [7:0]  FRAME_DATA;
  logic [15:0] FRAME_CNT;
  logic        ERR_SHORT, ERR_LONG, BUSY;

  dac_serial_rx_if ser ();

  dac_serial_rx dut (
    .tx_clk(tx_clk), .OPB_RST(OPB_RST), .ser(ser.slave), .CLR(CLR),
    .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA), .FRAME_STB(FRAME_STB),
    .FRAME_ADDR(FRAME_ADDR), .FRAME_DATA(FRAME_DATA),
    .FRAME_CNT(FRAME_CNT), .ERR_SHORT(ERR_SHORT),
    .ERR_LONG(ERR_LONG), .BUSY(BUSY)
  );

  always #5 tx_clk = ~tx_clk;

  typedef struct {
    logic [15:0] word;
    int          nbits;
    int          half;
    bit          trail;
    bit          commit;
    bit          e_short;
    bit          e_long;
  } vec_t;

  vec_t        vq[$];
  logic [7:0]  bank_m [8];
  int          checks = 0;
  int          errors = 0;
  int          stb_cnt = 0;
  int          stb0;
  logic [15:0] exp_cnt;
  bit          exp_short, exp_long;
  bit          seen;

  always @(negedge tx_clk) if (FRAME_STB) stb_cnt++;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(int n);
    repeat (n) @(negedge tx_clk);
  endtask

  task automatic send_bits(int nbits, logic [15:0] word, int half);
    for (int i = nbits - 1; i >= 0; i--) begin
      ser.SER_CLK = 1'b0;
      ser.SER_SDI = word[i];
      wait_clk(half);
      ser.SER_CLK = 1'b1;
      wait_clk(half);
    end
  endtask

  task automatic send_frame(int nbits, logic [15:0] word, int half, bit trail);
    ser.SER_CS = 1'b0;
    wait_clk(half);
    send_bits(nbits, word, half);
    ser.SER_CS = 1'b1;
    if (trail) begin
      wait_clk(half);
      ser.SER_CLK = 1'b0;
      ser.SER_SDI = 1'b0;
      wait_clk(half);
      ser.SER_CLK = 1'b1;
    end
    ser.SER_SDI = 1'bz;
    wait_clk(12);
  endtask

  function automatic vec_t mk(logic [15:0] w, int n, int h, bit t);
    vec_t v;
    v.word = w; v.nbits = n; v.half = h; v.trail = t;
    v.commit  = (n == 11);
    v.e_short = (n < 11);
    v.e_long  = (n > 11);
    return v;
  endfunction

  initial begin
    ser.SER_CS = 1'b1;
    ser.SER_CLK = 1'b1;
    ser.SER_SDI = 1'bz;
    for (int i = 0; i < 8; i++) bank_m[i] = '0;
    exp_cnt = '0; exp_short = 0; exp_long = 0;

    vq.push_back(mk(16'h05A7, 11, 4, 0));
    for (int a = 0; a < 8; a++)
      vq.push_back(mk(16'({3'(a), 8'(8'h10 + a)}), 11, 4, 0));
    vq.push_back(mk(16'h0333, 11, 2, 1));
    vq.push_back(mk(16'h07C4, 11, 2, 1));
    vq.push_back(mk(16'h0000, 11, 2, 1));
    vq.push_back(mk(16'h06FF, 11, 2, 1));
    vq.push_back(mk(16'h02A5, 10, 4, 0));
    vq.push_back(mk(16'h0ABC, 12, 4, 0));

    wait_clk(3);
    OPB_RST = 1'b0;
    wait_clk(2);
    check("rst_cnt", FRAME_CNT, 0);
    check("rst_short", ERR_SHORT, 0);
    check("rst_long", ERR_LONG, 0);
    check("rst_busy", BUSY, 0);
    check("rst_stb", stb_cnt, 0);
    check("rst_addr", FRAME_ADDR, 0);
    check("rst_rd", RD_DATA, 0);

    foreach (vq[k]) begin
      stb0 = stb_cnt;
      send_frame(vq[k].nbits, vq[k].word, vq[k].half, vq[k].trail);
      check($sformatf("v%0d_stb", k), stb_cnt - stb0, vq[k].commit ? 1 : 0);
      if (vq[k].commit) begin
        bank_m[vq[k].word[10:8]] = vq[k].word[7:0];
        exp_cnt++;
        check($sformatf("v%0d_faddr", k), FRAME_ADDR, vq[k].word[10:8]);
        check($sformatf("v%0d_fdata", k), FRAME_DATA, vq[k].word[7:0]);
      end
      exp_short |= vq[k].e_short;
      exp_long  |= vq[k].e_long;
      check($sformatf("v%0d_cnt", k), FRAME_CNT, exp_cnt);
      check($sformatf("v%0d_short", k), ERR_SHORT, exp_short);
      check($sformatf("v%0d_long", k), ERR_LONG, exp_long);
      check($sformatf("v%0d_busy", k), BUSY, 0);
      RD_ADDR = vq[k].word[10:8];
      wait_clk(1);
      check($sformatf("v%0d_rd", k), RD_DATA, bank_m[RD_ADDR]);
    end

    for (int a = 0; a < 8; a++) begin
      RD_ADDR = 3'(a);
      wait_clk(1);
      check($sformatf("sweep%0d", a), RD_DATA, bank_m[a]);
    end

    CLR = 1'b1; wait_clk(1); CLR = 1'b0; wait_clk(1);
    exp_cnt = '0;
    check("clr_cnt", FRAME_CNT, 0);
    check("clr_short", ERR_SHORT, 0);
    check("clr_long", ERR_LONG, 0);

    // CS glitch with no clocks counts as short
    stb0 = stb_cnt;
    ser.SER_CS = 1'b0; wait_clk(6); ser.SER_CS = 1'b1; wait_clk(12);
    check("glitch_stb", stb_cnt - stb0, 0);
    check("glitch_short", ERR_SHORT, 1);
    check("glitch_long", ERR_LONG, 0);
    CLR = 1'b1; wait_clk(1); CLR = 1'b0; wait_clk(1);

    // reset mid-frame, released with CS still low
    stb0 = stb_cnt;
    ser.SER_CS = 1'b0; wait_clk(4);
    send_bits(6, 16'h003A, 4);
    OPB_RST = 1'b1; wait_clk(2);
    RD_ADDR = 3'd3;
    wait_clk(1);
    check("mid_rst_rd", RD_DATA, 0);
    check("mid_rst_busy", BUSY, 0);
    OPB_RST = 1'b0;
    for (int i = 0; i < 8; i++) bank_m[i] = '0;
    wait_clk(3);
    check("mid_rst_idle", BUSY, 0);
    send_bits(5, 16'h0015, 4);
    ser.SER_CS = 1'b1; ser.SER_SDI = 1'bz; wait_clk(12);
    check("mid_rst_stb", stb_cnt - stb0, 0);
    check("mid_rst_cnt", FRAME_CNT, 0);
    check("mid_rst_short", ERR_SHORT, 0);
    stb0 = stb_cnt;
    send_frame(11, 16'h035C, 4, 0);
    check("post_rst_stb", stb_cnt - stb0, 1);
    check("post_rst_cnt", FRAME_CNT, 1);
    RD_ADDR = 3'd3; wait_clk(1);
    check("post_rst_rd", RD_DATA, 8'h5C);

    // counter wrap
    force dut.frame_cnt = 16'hFFFF;
    wait_clk(1);
    release dut.frame_cnt;
    wait_clk(1);
    check("preload", FRAME_CNT, 16'hFFFF);
    stb0 = stb_cnt;
    send_frame(11, 16'h0166, 4, 0);
    check("wrap_cnt", FRAME_CNT, 0);
    check("wrap_stb", stb_cnt - stb0, 1);

    // CLR coincident with the commit cycle
    force dut.frame_cnt = 16'hFFFF;
    wait_clk(1);
    release dut.frame_cnt;
    wait_clk(1);
    stb0 = stb_cnt;
    seen = 0;
    ser.SER_CS = 1'b0; wait_clk(4);
    send_bits(11, 16'h0499, 4);
    ser.SER_CS = 1'b1; ser.SER_SDI = 1'bz;
    for (int c = 0; c < 20 && !seen; c++) begin
      wait_clk(1);
      if (FRAME_STB) begin
        seen = 1;
        CLR = 1'b1;
        wait_clk(1);
        CLR = 1'b0;
      end
    end
    check("clrstb_seen", seen, 1);
    wait_clk(4);
    check("clrstb_cnt", FRAME_CNT, 0);
    check("clrstb_stb", stb_cnt - stb0, 1);
    check("clrstb_short", ERR_SHORT, 0);
    RD_ADDR = 3'd4; wait_clk(1);
    check("clrstb_rd", RD_DATA, 8'h99);
    check("clrstb_fdata", FRAME_DATA, 8'h99);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
